// File: rtl/umi_mux_pkg.sv
// Shared UMI definitions: arbitration-mode encodings used by the mux and its arbiter.
package umi_mux_pkg;

    localparam logic [1:0] UMI_ARB_RR    = 2'b00;
    localparam logic [1:0] UMI_ARB_FIXED = 2'b01;

endpackage

// File: rtl/umi_arbiter.sv
// N-way request arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
// The pointer advances past the winner only when the grant is actually consumed.
module umi_arbiter
    import umi_mux_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [1:0]   mode,
    input  logic [N-1:0] requests,
    input  logic         ready,
    output logic [N-1:0] grants
);

    localparam int unsigned PtrW = $clog2(N);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(N - 1);

    logic [PtrW-1:0] ptr_q, ptr_d, winner;
    logic            fixed, found;
    int              idx;

    always_comb begin
        case (mode)
            UMI_ARB_FIXED: fixed = 1'b1;
            UMI_ARB_RR:    fixed = 1'b0;
            default:       fixed = 1'b0;
        endcase
    end

    // Scan candidates in priority order; the first asserted request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = 0; off < int'(N); off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (fixed) idx = off;
            if (!found && requests[idx]) begin
                found  = 1'b1;
                winner = PtrW'(idx);
            end
        end
    end

    always_comb begin
        grants         = '0;
        grants[winner] = found;
        ptr_d          = ptr_q;
        if (ready && found) begin
            ptr_d = (winner == LastIdx) ? '0 : winner + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/umi_mux.sv
// N-input UMI request merger: arbitrates single-beat packets into one registered output
// stage that can drain and refill on the same edge.
module umi_mux
    import umi_mux_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned UW     = 256,
    parameter string       TARGET = "DEFAULT"
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*UW-1:0] umi_in_packet,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [UW-1:0]   umi_out_packet,
    input  logic            umi_out_ready
);

    logic          load;
    logic [N-1:0]  grant;
    logic [UW-1:0] mux_packet;
    logic [UW-1:0] packet_q, packet_d;
    logic          out_valid_q, out_valid_d;

    // Gating with nreset keeps every source unacknowledged while reset is held.
    assign load = (~out_valid_q | umi_out_ready) & nreset;

    umi_arbiter #(
        .N (N)
    ) u_arb (
        .clk      (clk),
        .nreset   (nreset),
        .mode     (mode),
        .requests (umi_in_valid),
        .ready    (load),
        .grants   (grant)
    );

    assign umi_in_ready = grant & {N{load}};

    // Grant is one-hot or zero, so an AND-OR select is sufficient.
    always_comb begin
        mux_packet = '0;
        for (int i = 0; i < int'(N); i++) begin
            mux_packet |= {UW{grant[i]}} & umi_in_packet[i*UW +: UW];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        packet_d    = packet_q;
        if (load) begin
            out_valid_d = |grant;
            if (|grant) packet_d = mux_packet;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid_q <= 1'b0;
            packet_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            packet_q    <= packet_d;
        end
    end

    assign umi_out_valid  = out_valid_q;
    assign umi_out_packet = packet_q;

    // Hook for target-specific implementations; the generic target needs nothing extra.
    if (TARGET != "DEFAULT") begin : g_target_hook
    end

endmodule

// File: tb/tb_umi_mux.sv
// Directed bench for umi_mux: reset, round-robin, fixed priority, backpressure,
// sparse/wrap and mid-operation reset.
module tb_umi_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned UW = 32;

    logic            clk = 1'b0;
    logic            nreset;
    logic [1:0]      mode;
    logic [N-1:0]    umi_in_valid;
    logic [N*UW-1:0] umi_in_packet;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [UW-1:0]   umi_out_packet;
    logic            umi_out_ready;

    int vectors     = 0;
    int miscompares = 0;
    int seq[N];
    int acc[N];

    always #5 clk = ~clk;

    umi_mux #(
        .N      (N),
        .UW     (UW),
        .TARGET ("DEFAULT")
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .mode           (mode),
        .umi_in_valid   (umi_in_valid),
        .umi_in_packet  (umi_in_packet),
        .umi_in_ready   (umi_in_ready),
        .umi_out_valid  (umi_out_valid),
        .umi_out_packet (umi_out_packet),
        .umi_out_ready  (umi_out_ready)
    );

    function automatic logic [UW-1:0] make_pkt(int port, int s);
        return {8'hA5, 8'(port), 16'(s)};
    endfunction

    task automatic present_all();
        for (int i = 0; i < int'(N); i++) umi_in_packet[i*UW +: UW] = make_pkt(i, seq[i]);
    endtask

    // One clock; a source whose ready was high moves on to its next packet.
    task automatic cycle();
        logic [N-1:0] rdy;
        rdy = umi_in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (rdy[i]) begin
                seq[i]++;
                acc[i]++;
            end
        end
        present_all();
        #1;
    endtask

    task automatic do_reset();
        umi_in_valid = '0;
        nreset = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        mode = 2'b00;
        umi_out_ready = 1'b1;
        umi_in_valid = 4'b1111;
        present_all();
        #2;
        vectors++;
        if (umi_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", umi_out_valid);
        end
        vectors++;
        if (umi_in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 0000", umi_in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (umi_out_valid !== 1'b0 || umi_out_packet !== '0) begin
            miscompares++;
            $display("FAIL reset_held: got valid %b pkt %h want 0/0", umi_out_valid,
                     umi_out_packet);
        end
        nreset = 1'b1;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b want 0001", umi_in_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        int p;
        for (int i = 0; i < int'(N); i++) acc[i] = 0;
        for (int c = 0; c < 16; c++) begin
            p = c % 4;
            exp = 4'b0001 << p;
            vectors++;
            if (umi_in_ready !== exp) begin
                miscompares++;
                $display("FAIL rr_ready c=%0d: got %b want %b", c, umi_in_ready, exp);
            end
            cycle();
            vectors++;
            if (umi_out_valid !== 1'b1 || umi_out_packet !== make_pkt(p, seq[p] - 1)) begin
                miscompares++;
                $display("FAIL rr_out c=%0d: got %b/%h want 1/%h", c, umi_out_valid,
                         umi_out_packet, make_pkt(p, seq[p] - 1));
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            vectors++;
            if (acc[i] !== 4) begin
                miscompares++;
                $display("FAIL rr_accepts port%0d: got %0d want 4", i, acc[i]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mode = 2'b01;
        umi_in_valid = 4'b1010;
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (umi_in_ready !== 4'b0010) begin
                miscompares++;
                $display("FAIL fixed_ready c=%0d: got %b want 0010", c, umi_in_ready);
            end
            cycle();
            vectors++;
            if (umi_out_packet !== make_pkt(1, seq[1] - 1)) begin
                miscompares++;
                $display("FAIL fixed_out c=%0d: got %h want %h", c, umi_out_packet,
                         make_pkt(1, seq[1] - 1));
            end
        end
        umi_in_valid = 4'b1000;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL fixed_port3_ready: got %b want 1000", umi_in_ready);
        end
        cycle();
        vectors++;
        if (umi_out_packet !== make_pkt(3, seq[3] - 1)) begin
            miscompares++;
            $display("FAIL fixed_port3_out: got %h want %h", umi_out_packet,
                     make_pkt(3, seq[3] - 1));
        end
        umi_in_valid = 4'b0000;
        cycle();
        vectors++;
        if (umi_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_idle: got %b want 0", umi_out_valid);
        end
        mode = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [UW-1:0] held;
        do_reset();
        umi_out_ready = 1'b0;
        umi_in_valid = 4'b0001;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL bp_fill_ready: got %b want 0001", umi_in_ready);
        end
        held = make_pkt(0, seq[0]);
        cycle();
        umi_in_valid = 4'b0100;
        #1;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (umi_in_ready !== 4'b0000 || umi_out_valid !== 1'b1 || umi_out_packet !== held)
            begin
                miscompares++;
                $display("FAIL bp_stall c=%0d: got rdy %b v %b pkt %h want 0000/1/%h", c,
                         umi_in_ready, umi_out_valid, umi_out_packet, held);
            end
            cycle();
        end
        umi_out_ready = 1'b1;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b want 0100", umi_in_ready);
        end
        cycle();
        vectors++;
        if (umi_out_valid !== 1'b1 || umi_out_packet !== make_pkt(2, seq[2] - 1)) begin
            miscompares++;
            $display("FAIL bp_refill: got %b/%h want 1/%h", umi_out_valid, umi_out_packet,
                     make_pkt(2, seq[2] - 1));
        end
        umi_in_valid = 4'b0000;
        cycle();
    endtask

    task automatic test_sparse_wrap();
        logic [UW-1:0] last;
        do_reset();
        umi_in_valid = 4'b1000;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL sparse_p3_ready: got %b want 1000", umi_in_ready);
        end
        last = make_pkt(3, seq[3]);
        cycle();
        umi_in_valid = 4'b0000;
        #1;
        cycle();
        vectors++;
        if (umi_out_valid !== 1'b0 || umi_out_packet !== last) begin
            miscompares++;
            $display("FAIL sparse_idle: got %b/%h want 0/%h", umi_out_valid, umi_out_packet,
                     last);
        end
        umi_in_valid = 4'b1001;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL sparse_wrap_ready: got %b want 0001", umi_in_ready);
        end
        cycle();
        vectors++;
        if (umi_out_packet !== make_pkt(0, seq[0] - 1)) begin
            miscompares++;
            $display("FAIL sparse_wrap_out: got %h want %h", umi_out_packet,
                     make_pkt(0, seq[0] - 1));
        end
        umi_in_valid = 4'b1010;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL sparse_ptr1_ready: got %b want 0010", umi_in_ready);
        end
        cycle();
        umi_in_valid = 4'b1000;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL sparse_p3_again: got %b want 1000", umi_in_ready);
        end
        cycle();
        umi_in_valid = 4'b0000;
        cycle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        mode = 2'b10;
        umi_out_ready = 1'b0;
        umi_in_valid = 4'b1111;
        #1;
        cycle();
        vectors++;
        if (umi_out_valid !== 1'b1 || umi_in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_full: got v %b rdy %b want 1/0000", umi_out_valid,
                     umi_in_ready);
        end
        nreset = 1'b0;
        #1;
        vectors++;
        if (umi_out_valid !== 1'b0 || umi_in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_drop: got v %b rdy %b want 0/0000", umi_out_valid,
                     umi_in_ready);
        end
        umi_out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (umi_in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_no_ack: got %b want 0000", umi_in_ready);
        end
        nreset = 1'b1;
        #1;
        vectors++;
        if (umi_in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_release: got %b want 0001", umi_in_ready);
        end
        cycle();
        vectors++;
        if (umi_in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL mode1x_rr: got %b want 0010", umi_in_ready);
        end
        umi_in_valid = 4'b0000;
        cycle();
        mode = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) seq[i] = i * 16;
        umi_in_packet = '0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_sparse_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/umi_mux.md
# umi_mux

N-input UMI arbiter with a registered output stage. It merges several single-beat UMI request streams into one stream, and it sits directly upstream of `umi_fifo`, whose `umi_in_*` ports it drives. Arbitration is round-robin by default, with an optional fixed-priority mode. The output register decouples arbiter timing from the FIFO write path and sustains one packet per cycle.

## Interface
- `N`, 4: number of input ports (2..16).
- `UW`, 256: UMI packet width.
- `TARGET`, "DEFAULT": implementation target, passed through for consistency.

- `clk` in 1: single clock, used for all logic.
- `nreset` in 1: reset, asynchronous assert, active-low.
- `mode` in 2: arbitration mode.
  - 2'b00: round-robin.
  - 2'b01: fixed priority, lowest index wins.
  - 2'b1x: treated as round-robin.
- `umi_in_valid` in N: per-port packet valid.
- `umi_in_packet` in N*UW: port i occupies bits `[i*UW +: UW]`.
- `umi_in_ready` out N: per-port accept.
- `umi_out_valid` out 1: output packet valid.
- `umi_out_packet` out UW: output packet.
- `umi_out_ready` in 1: downstream accept (`umi_fifo` `umi_in_ready`).

## Operation
- Handshake on both sides is valid/ready. A transfer occurs on a rising `clk` edge when valid and ready are both high.
- Once valid is asserted, a source holds valid and packet stable until it is accepted. The block never drops a packet that is presented and not accepted.
- `load = ~out_valid_q | umi_out_ready`. The output register can take a new packet this cycle.
- `grant[N-1:0]` is combinational, one-hot or zero, and derived from `umi_in_valid`, `mode` and the priority pointer `ptr`.
  - Round-robin: the first requester at or after `ptr`, searching upward with wrap-around.
  - Fixed priority: the lowest asserted index, regardless of `ptr`.
- `umi_in_ready[i] = grant[i] & load`. At most one ready is high per cycle.
- When `load` is high and any grant is high:
  - the register captures the granted packet;
  - `out_valid_q` is set to 1;
  - `ptr` becomes `(winner + 1) mod N`, in both modes.
- When `load` is high and no port requests: `out_valid_q` is set to 0, the packet register is held, and `ptr` is unchanged.
- When `load` is low: all registers hold.
- `umi_out_valid = out_valid_q` and `umi_out_packet = packet_q`. There is no combinational path from inputs to outputs.
- A change of `mode` takes effect on the next arbitration cycle. A packet already in the register is unaffected.

## Timing
- Reset values: `out_valid_q` = 0, `packet_q` = 0, `ptr` = 0. All `umi_in_ready` are 0 whenever all inputs are idle.
- Latency: a packet accepted at edge k is visible on `umi_out_*` after edge k and transfers downstream at edge k+1 or later.
- Throughput: one packet per cycle while `umi_out_ready` stays high.
- Simultaneous drain and fill (`out_valid_q=1`, `umi_out_ready=1`, a requester present): the old packet leaves and the new one is loaded on the same edge, with no bubble.
- Stall (`umi_out_ready=0` with `out_valid_q=1`): all `umi_in_ready` are 0, and `ptr` and the register hold.
- Grant may move while stalled if a higher-priority request arrives. This is legal because no transfer occurs.
- Wrap-around: with winner N-1, `ptr` becomes 0.
- Reset mid-operation: the packet held in the register is discarded, `umi_out_valid` drops immediately, and no input is acknowledged until `nreset` deasserts.
- `umi_in_ready` is combinational from `umi_out_ready`, `umi_in_valid` and `mode`.
- `umi_out_ready` may depend on `umi_out_valid`. It must not depend combinationally on `umi_in_ready`.

## Structure
- The arbitration-mode encodings (`UMI_ARB_RR`, `UMI_ARB_FIXED`) belong in the shared UMI package/header. No other typedefs are required.
- One sub-module, `umi_arbiter`.
  - Ports: `clk`, `nreset`, `mode`, `requests[N-1:0]`, `ready` (= `load`), `grants[N-1:0]`.
  - It owns `ptr` and the round-robin / fixed-priority logic.
- `umi_mux` owns the packet multiplexer (AND-OR on the one-hot grant) and the output register.

## Test plan
- **Reset:** assert `nreset`=0 with all inputs valid → `umi_out_valid`=0, all `umi_in_ready`=0. After release, the first grant goes to port 0.
- **Round-robin fairness:** N=4, all ports valid continuously, `umi_out_ready`=1, packets tagged with the port number.
  - Output order is 0,1,2,3,0,1…
  - One packet per cycle; exactly 4 accepts per port over 16 cycles.
- **Fixed priority:** `mode`=01, ports 1 and 3 always valid.
  - Output is all port 1 until port 1 drops; port 3 follows the next cycle.
- **Backpressure:** fill the register, hold `umi_out_ready`=0 for 5 cycles while port 2 is valid.
  - `umi_out_packet` is stable and `umi_in_ready` stays 0.
  - On release, the held packet transfers and port 2's packet is loaded on the same edge.
- **Sparse/wrap:** only port 3 valid, then only port 0.
  - `ptr` goes 0→0 (port 3 wins, `ptr`=0), then port 0 wins.
  - Idle cycles drop `umi_out_valid` to 0 with `ptr` unchanged.
- **Integration:** drive into `umi_fifo` with `chaosmode`=1 and random valids.
  - A scoreboard sees no loss or duplication.
  - Per-port ordering is preserved.
